display_seg_driver: RTL and testbench

- Downstream stage of the 4-digit scan generator. Consumes its one-hot digit-select vector and drives the shared 7-segment bus and the per-digit anodes.
- Holds a double-buffered 4-digit BCD value, loaded via a valid/ready handshake and committed only at frame boundaries to prevent tearing.
- Inserts anode blanking on every select change to suppress ghosting.
- Supports leading-zero suppression and flags illegal select codes.

---
 rtl/display_seg_driver.sv | 161 ++++++++++++++++
 tb/tb_display_seg_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_seg_driver.sv
// 4-digit 7-segment output stage: double-buffered BCD value, frame-aligned commit,
// anode blanking on every select change, leading-zero suppression, illegal-select flag.
module display_seg_driver #(
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_sel,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_dp,
  output logic        in_ready,
  input  logic        lz_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done,
  output logic        sel_err
);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  // Handshake: a word transfers on in_valid && in_ready. in_ready is registered,
  // drops the cycle after a transfer and rises the cycle after the pending word
  // commits. in_valid seen while in_ready is low is ignored; the sender holds it.

  logic [3:0]       sel_q;
  logic [CNT_W-1:0] blank_cnt;
  logic [15:0]      shadow_data;
  logic [3:0]       shadow_dp;
  logic [15:0]      pend_data;
  logic [3:0]       pend_dp;

  logic             sel_legal;
  logic [1:0]       sel_idx;
  logic             sel_change;
  logic             boundary;
  logic             xfer;
  logic             commit;
  logic [CNT_W-1:0] cnt_nxt;
  logic [15:0]      shadow_data_nxt;
  logic [3:0]       shadow_dp_nxt;
  logic [3:0]       nib;
  logic             suppress;
  logic             active;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       an_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    sel_legal = 1'b1;
    sel_idx   = 2'd0;
    case (digit_sel)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_legal = 1'b0;
    endcase

    sel_change = (digit_sel != sel_q);
    // An illegal code can never equal 4'b0001, so it never forms a boundary.
    boundary   = (digit_sel == 4'b0001) && (sel_q != 4'b0001);
    xfer       = in_valid && in_ready;
    commit     = boundary && !in_ready;

    cnt_nxt = blank_cnt;
    if (sel_change)
      cnt_nxt = BLANK_LOAD;
    else if (blank_cnt != '0)
      cnt_nxt = blank_cnt - CNT_ONE;

    shadow_data_nxt = commit ? pend_data : shadow_data;
    shadow_dp_nxt   = commit ? pend_dp   : shadow_dp;

    nib      = shadow_data_nxt[{sel_idx, 2'b00} +: 4];
    suppress = 1'b0;
    if (lz_en) begin
      case (sel_idx)
        2'd3:    suppress = (shadow_data_nxt[15:12] == 4'h0);
        2'd2:    suppress = (shadow_data_nxt[15:8]  == 8'h00);
        2'd1:    suppress = (shadow_data_nxt[15:4]  == 12'h000);
        default: suppress = 1'b0;
      endcase
    end

    // Outputs are built from next-cycle state so the blank window starts on the
    // same edge that observes the select change.
    active  = sel_legal && (cnt_nxt == '0);
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    an_nxt  = 4'hF;
    if (active) begin
      seg_nxt = suppress ? SEG_OFF : bcd_to_seg(nib);
      dp_nxt  = ~shadow_dp_nxt[sel_idx];
      an_nxt  = ~digit_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 4'h0;
      blank_cnt   <= BLANK_LOAD;
      shadow_data <= 16'h0000;
      shadow_dp   <= 4'h0;
      pend_data   <= 16'h0000;
      pend_dp     <= 4'h0;
      in_ready    <= 1'b1;
    end else begin
      sel_q       <= digit_sel;
      blank_cnt   <= cnt_nxt;
      shadow_data <= shadow_data_nxt;
      shadow_dp   <= shadow_dp_nxt;
      if (xfer) begin
        pend_data <= in_data;
        pend_dp   <= in_dp;
        in_ready  <= 1'b0;
      end else if (commit) begin
        in_ready  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
      an_n       <= an_nxt;
      frame_done <= boundary;
      sel_err    <= !sel_legal;
    end
  end

endmodule

// File: tb/tb_display_seg_driver.sv
// Self-checking bench for display_seg_driver: expected display words are queued as
// each select cycle is driven and compared once the registered outputs settle.
module tb_display_seg_driver;

  localparam int BLANK = 2;
  localparam logic [11:0] OFFW = {4'hF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  digit_sel = 4'h0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_dp = 4'h0;
  logic        lz_en = 1'b0;
  logic        in_ready;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;
  logic        sel_err;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  logic [11:0] exp_q[$];

  display_seg_driver #(.BLANK_CYCLES(BLANK), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .digit_sel(digit_sel), .in_valid(in_valid),
    .in_data(in_data), .in_dp(in_dp), .in_ready(in_ready), .lz_en(lz_en),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [11:0] exp_digit(input logic [15:0] sh, input logic [3:0] shdp,
                                            input int d, input logic lz);
    logic [3:0] an;
    logic [6:0] s;
    logic sup;
    sup = 1'b0;
    if (lz) begin
      if (d == 3) sup = (sh[15:12] == 4'h0);
      if (d == 2) sup = (sh[15:8] == 8'h00);
      if (d == 1) sup = (sh[15:4] == 12'h000);
    end
    s = sup ? 7'h7F : seg_of(sh[d*4 +: 4]);
    an = 4'hF;
    an[d] = 1'b0;
    return {an, s, ~shdp[d]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_sel(input logic [3:0] sel, input int n, input logic [11:0] shown,
                          input int blank, input logic offer, input logic [15:0] od,
                          input logic [3:0] odp);
    logic [11:0] exp_w, got;
    for (int i = 0; i < n; i++) begin
      digit_sel = sel;
      if (offer) begin
        in_valid = (i == 0);
        in_data  = od;
        in_dp    = odp;
      end
      exp_q.push_back(i < blank ? OFFW : shown);
      tick();
      if (frame_done) fd_cnt++;
      got = {an_n, seg_n, dp_n};
      exp_w = exp_q.pop_front();
      checks++;
      if (got !== exp_w) begin
        errors++;
        $display("FAIL display sel=%b cyc=%0d: got an_n=%h seg_n=%h dp_n=%b, expected an_n=%h seg_n=%h dp_n=%b",
                 sel, i, got[11:8], got[7:1], got[0], exp_w[11:8], exp_w[7:1], exp_w[0]);
      end
    end
    if (offer) in_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic run_frame(input logic [15:0] sh, input logic [3:0] shdp, input logic offer,
                           input logic [15:0] od, input logic [3:0] odp);
    fd_cnt = 0;
    hold_sel(4'b0001, 8, exp_digit(sh, shdp, 0, lz_en), BLANK, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b0010, 8, exp_digit(sh, shdp, 1, lz_en), BLANK, offer, od, odp);
    if (offer) check_bit("ready_after_load", in_ready, 1'b0);
    hold_sel(4'b0100, 8, exp_digit(sh, shdp, 2, lz_en), BLANK, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b1000, 8, exp_digit(sh, shdp, 3, lz_en), BLANK, 1'b0, 16'h0, 4'h0);
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses, expected 1", fd_cnt);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    digit_sel = 4'b0001;
    #1 rst_n = 1'b0;
    #2;
    got = {an_n, seg_n, dp_n, in_ready, frame_done, sel_err};
    checks++;
    if (got !== {OFFW, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h, expected %h", got, {OFFW, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fd_cnt = 0;
    hold_sel(4'b0001, 3, {4'hE, 7'h40, 1'b1}, BLANK, 1'b0, 16'h0, 4'h0);
    check_bit("ready_after_reset", in_ready, 1'b1);
    check_bit("first_boundary_pulse", fd_cnt == 1, 1'b1);
    hold_sel(4'b1000, 4, {4'h7, 7'h40, 1'b1}, BLANK, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic test_load_rotate();
    run_frame(16'h0000, 4'h0, 1'b1, 16'h1234, 4'b0100);
    run_frame(16'h1234, 4'b0100, 1'b0, 16'h0, 4'h0);
    check_bit("ready_after_commit", in_ready, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_frame(16'h1234, 4'b0100, 1'b1, 16'h5678, 4'h0);
    in_valid = 1'b1;
    in_data  = 16'h9999;
    in_dp    = 4'hF;
    hold_sel(4'b1000, 1, exp_digit(16'h1234, 4'b0100, 3, 1'b0), 0, 1'b0, 16'h0, 4'h0);
    check_bit("ready_while_full", in_ready, 1'b0);
    hold_sel(4'b0001, 1, OFFW, 1, 1'b0, 16'h0, 4'h0);
    check_bit("ready_on_commit", in_ready, 1'b1);
    hold_sel(4'b0001, 1, OFFW, 1, 1'b0, 16'h0, 4'h0);
    check_bit("held_word_taken", in_ready, 1'b0);
    in_valid = 1'b0;
    hold_sel(4'b0001, 6, exp_digit(16'h5678, 4'h0, 0, 1'b0), 0, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b0010, 8, exp_digit(16'h5678, 4'h0, 1, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b0100, 8, exp_digit(16'h5678, 4'h0, 2, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b1000, 8, exp_digit(16'h5678, 4'h0, 3, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
    run_frame(16'h9999, 4'hF, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    run_frame(16'h9999, 4'hF, 1'b1, 16'h0050, 4'h0);
    run_frame(16'h0050, 4'h0, 1'b1, 16'h0000, 4'h0);
    run_frame(16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    lz_en = 1'b0;
  endtask

  task automatic test_illegal();
    logic [11:0] exp_w, got;
    fd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      digit_sel = 4'b0110;
      exp_q.push_back(OFFW);
      tick();
      if (frame_done) fd_cnt++;
      got = {an_n, seg_n, dp_n};
      exp_w = exp_q.pop_front();
      checks++;
      if (got !== exp_w) begin
        errors++;
        $display("FAIL illegal_outputs cyc=%0d: got %h, expected %h", i, got, exp_w);
      end
      check_bit("sel_err_high", sel_err, 1'b1);
    end
    check_bit("no_boundary_on_illegal", fd_cnt == 0, 1'b1);
    hold_sel(4'b0001, 1, OFFW, 1, 1'b0, 16'h0, 4'h0);
    check_bit("sel_err_cleared", sel_err, 1'b0);
    check_bit("boundary_on_return", fd_cnt == 1, 1'b1);
    hold_sel(4'b0001, 7, exp_digit(16'h0000, 4'h0, 0, 1'b0), 1, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b1000, 4, exp_digit(16'h0000, 4'h0, 3, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic test_dash_and_reset();
    logic [15:0] got;
    run_frame(16'h0000, 4'h0, 1'b1, 16'h00B0, 4'h0);
    run_frame(16'h00B0, 4'h0, 1'b0, 16'h0, 4'h0);
    hold_sel(4'b0010, 4, exp_digit(16'h00B0, 4'h0, 1, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    got = {an_n, seg_n, dp_n, in_ready, frame_done, sel_err};
    checks++;
    if (got !== {OFFW, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_mid_digit: got %h, expected %h", got, {OFFW, 1'b1, 1'b0, 1'b0});
    end
    #1 rst_n = 1'b1;
    hold_sel(4'b0010, 4, exp_digit(16'h0000, 4'h0, 1, 1'b0), BLANK, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_load_rotate();
    test_back_to_back();
    test_lz();
    test_illegal();
    test_dash_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
